// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
//               Holds the responder FSM state encoding and the funct3 codes
//               (instruction bits [14:12]) used for load/store sizing.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Responder FSM states; only used when DMEM_LATENCY_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // funct3 access codes. Byte/half/word are shared by loads and stores;
  // the unsigned variants exist only for loads.
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

endpackage
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_align
// Description : Combinational lane logic for the data memory. Checks funct3
//               legality and alignment, builds store byte enables and the
//               lane-shifted store data, and extracts/extends load data.
// Ports       : i_is_store   - access is a store (else load)
//               i_funct3     - access size / signedness
//               i_addr_lo    - byte address bits [1:0]
//               i_wdata      - right-aligned store data
//               i_mem_word   - addressed memory word
//               o_legal      - funct3 legal for this direction and aligned
//               o_byte_en    - byte lanes to write on a store
//               o_wdata_lane - store data shifted into its lanes
//               o_load_data  - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_align
  import dmem_pkg::*;
(
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_word,
  output logic        o_legal,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata_lane,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shifted;

  // Shifting the word right by the byte offset puts the addressed byte or
  // half at bit 0; halves are only legal when aligned, so this also covers
  // the upper half.
  assign w_shifted    = i_mem_word >> {i_addr_lo, 3'b000};
  assign o_wdata_lane = i_wdata << {i_addr_lo, 3'b000};

  always_comb begin
    o_legal     = 1'b0;
    o_byte_en   = 4'b0000;
    o_load_data = 32'h0000_0000;
    case (i_funct3)
      c_f3_b: begin
        o_legal     = 1'b1;
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      c_f3_h: begin
        o_legal     = ~i_addr_lo[0];
        o_byte_en   = 4'b0011 << i_addr_lo;
        o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      c_f3_w: begin
        o_legal     = (i_addr_lo == 2'b00);
        o_byte_en   = 4'b1111;
        o_load_data = i_mem_word;
      end
      c_f3_bu: begin
        o_legal     = ~i_is_store;
        o_load_data = {24'h000000, w_shifted[7:0]};
      end
      c_f3_hu: begin
        o_legal     = ~i_is_store & ~i_addr_lo[0];
        o_load_data = {16'h0000, w_shifted[15:0]};
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the pipeline. Serves byte/half/word
//               loads and stores against an internal word memory, flags
//               misaligned or illegal accesses, and (optionally) models a
//               fixed access latency by stalling the pipeline.
// Config      : DMEM_LATENCY_EN - when defined, each access stalls for
//               MEM_DELAY cycles through an IDLE/BUSY/RESP FSM. When
//               undefined, the access happens at the request edge, the
//               response follows one cycle later and stall is tied low.
// Parameters  : DEPTH     - memory size in 32-bit words (power of two)
//               MEM_DELAY - response latency in cycles (>= 1)
// Ports       : clk    - clock, rising edge
//               nrst   - synchronous active-low reset
//               re/we  - load / store request (both high = store)
//               funct3 - access size and signedness
//               addr   - byte address (wraps modulo DEPTH*4)
//               wdata  - right-aligned store data
//               rdata  - extended load result, held until the next load
//               valid  - one-cycle response strobe
//               stall  - pipeline stall to the control unit
//               err    - one-cycle misaligned/illegal request flag
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int MEM_DELAY = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        stall,
  output logic        err
);

  localparam int c_idx_w = $clog2(DEPTH);

  // Memory contents are deliberately not reset.
  logic [31:0]        r_mem [DEPTH];
  logic [31:0]        r_rdata;

  // Request currently being evaluated or executed.
  logic               w_sel_store;
  logic [2:0]         w_sel_funct3;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic               w_req;        // new request presented while able to take it
  logic               w_accept;
  logic               w_do_access;  // memory access happens at this edge

  logic [c_idx_w-1:0] w_idx;
  logic               w_legal;
  logic [3:0]         w_byte_en;
  logic [31:0]        w_wdata_lane;
  logic [31:0]        w_load_data;

  // Address bits above the word index are ignored so accesses wrap.
  logic               w_unused_addr;
  assign w_unused_addr = &{1'b0, w_sel_addr[31:c_idx_w+2]};

  assign w_idx    = w_sel_addr[c_idx_w+1:2];
  assign w_accept = w_req & w_legal;
  assign err      = nrst & w_req & ~w_legal;
  assign rdata    = r_rdata;

  dmem_align u_align (
    .i_is_store   (w_sel_store),
    .i_funct3     (w_sel_funct3),
    .i_addr_lo    (w_sel_addr[1:0]),
    .i_wdata      (w_sel_wdata),
    .i_mem_word   (r_mem[w_idx]),
    .o_legal      (w_legal),
    .o_byte_en    (w_byte_en),
    .o_wdata_lane (w_wdata_lane),
    .o_load_data  (w_load_data)
  );

`ifdef DMEM_LATENCY_EN

  localparam int                 c_cnt_w    = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  // With a one-cycle latency there is no wait phase.
  localparam dmem_state_e        c_first    = (MEM_DELAY > 1) ? BUSY : RESP;

  dmem_state_e        r_state;
  dmem_state_e        w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_stall;
  logic               w_idle;

  // Copy of the accepted request; the CU holds its inputs while stalled,
  // but only this copy is trusted after acceptance.
  logic               r_store;
  logic [2:0]         r_funct3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;

  assign w_idle       = (r_state == IDLE);
  assign w_sel_store  = w_idle ? we     : r_store;
  assign w_sel_funct3 = w_idle ? funct3 : r_funct3;
  assign w_sel_addr   = w_idle ? addr   : r_addr;
  assign w_sel_wdata  = w_idle ? wdata  : r_wdata;
  // Inputs seen in BUSY/RESP belong to the instruction already in flight.
  assign w_req        = w_idle & (re | we);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_stall     = 1'b1;
          w_state_nxt = c_first;
          w_cnt_nxt   = (MEM_DELAY > 1) ? c_cnt_one : '0;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
    end else if (w_accept) begin
      r_store  <= we;
      r_funct3 <= funct3;
      r_addr   <= addr;
      r_wdata  <= wdata;
    end
  end

  // Memory is touched only on the edge entering RESP, so a reset during
  // BUSY aborts the access cleanly.
  assign w_do_access = nrst & (w_state_nxt == RESP);
  assign stall       = nrst & w_stall;
  assign valid       = nrst & (r_state == RESP);

`else

  logic r_valid;

  localparam int c_unused_delay = MEM_DELAY;

  assign w_sel_store  = we;
  assign w_sel_funct3 = funct3;
  assign w_sel_addr   = addr;
  assign w_sel_wdata  = wdata;
  assign w_req        = re | we;
  assign w_do_access  = nrst & w_accept;
  assign stall        = 1'b0;
  assign valid        = r_valid;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
    end
  end

`endif

  // Load results are registered on the access edge and held across stores.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rdata <= 32'h0000_0000;
    end else if (w_do_access && !w_sel_store) begin
      r_rdata <= w_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_access && w_sel_store) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_lane[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed testbench for dmem_responder. A reference memory
//               predicts each response, which is queued when the request is
//               driven and compared when valid is seen. Stall/err/valid
//               timing is checked cycle by cycle for the configured build
//               (DMEM_LATENCY_EN defined or not).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH     = 1024;
  localparam int MEM_DELAY = 4;
`ifdef DMEM_LATENCY_EN
  localparam int   LAT    = MEM_DELAY;
  localparam logic LAT_EN = 1'b1;
`else
  localparam int   LAT    = 1;
  localparam logic LAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        re;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;
  logic        stall;
  logic        err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] ref_mem [int];
  logic [31:0] m_rdata;

  dmem_responder #(
    .DEPTH     (DEPTH),
    .MEM_DELAY (MEM_DELAY)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .re     (re),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .valid  (valid),
    .stall  (stall),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_mem[widx(a)];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
    case (f3)
      3'b000:  w[8*a[1:0] +: 8] = wd[7:0];
      3'b001:  w[16*a[1] +: 16] = wd[15:0];
      default: w = wd;
    endcase
    ref_mem[widx(a)] = w;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("valid_unexpected", {31'b0, valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  // One legal access. scr perturbs the inputs during BUSY (latency build)
  // to show that only the captured request is used.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic scr);
    logic [31:0] e;
    @(posedge clk); #1;
    re = r; we = w; funct3 = f3; addr = a; wdata = wd;
    if (w) begin
      model_store(f3, a, wd);
      e = m_rdata;
    end else begin
      e = model_load(f3, a);
      m_rdata = e;
    end
    exp_q.push_back(e);
    @(negedge clk);
    check($sformatf("%s/stall_c0", tag), {31'b0, stall}, {31'b0, LAT_EN});
    check($sformatf("%s/err_c0", tag), {31'b0, err}, 32'd0);
    check($sformatf("%s/valid_c0", tag), {31'b0, valid}, 32'd0);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
`ifdef DMEM_LATENCY_EN
      if (scr && k < LAT) begin
        addr = a ^ 32'h40; wdata = ~wd; funct3 = 3'b010;
      end else begin
        addr = a; wdata = wd; funct3 = f3;
      end
`else
      re = 1'b0; we = 1'b0;
      if (scr) addr = a ^ 32'h40;
`endif
      @(negedge clk);
      check($sformatf("%s/stall_c%0d", tag, k), {31'b0, stall},
            (k < LAT) ? {31'b0, LAT_EN} : 32'd0);
      check($sformatf("%s/valid_c%0d", tag, k), {31'b0, valid}, {31'b0, (k == LAT)});
    end
  endtask

  task automatic bad(input string tag, input logic r, input logic w,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    re = r; we = w; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    check($sformatf("%s/err", tag), {31'b0, err}, 32'd1);
    check($sformatf("%s/stall", tag), {31'b0, stall}, 32'd0);
    check($sformatf("%s/valid", tag), {31'b0, valid}, 32'd0);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
    @(negedge clk);
    check($sformatf("%s/err_next", tag), {31'b0, err}, 32'd0);
    check($sformatf("%s/valid_next", tag), {31'b0, valid}, 32'd0);
    check($sformatf("%s/rdata_held", tag), rdata, m_rdata);
  endtask

  task automatic idle(input string tag);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
    @(negedge clk);
    check($sformatf("%s/stall", tag), {31'b0, stall}, 32'd0);
    check($sformatf("%s/valid", tag), {31'b0, valid}, 32'd0);
    check($sformatf("%s/err", tag), {31'b0, err}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    nrst = 1'b0; re = 1'b1; we = 1'b0; funct3 = c_f3_w; addr = 32'h10; wdata = 32'h0;
    m_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/stall", {31'b0, stall}, 32'd0);
    check("rst/err", {31'b0, err}, 32'd0);
    check("rst/valid", {31'b0, valid}, 32'd0);
    check("rst/rdata", rdata, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1; re = 1'b0;
    idle("idle0");

    access("sw10",  1'b0, 1'b1, c_f3_w,  32'h10, 32'hDEADBEEF, 1'b1);
    access("lw10",  1'b1, 1'b0, c_f3_w,  32'h10, 32'h0, 1'b0);
    access("lb13",  1'b1, 1'b0, c_f3_b,  32'h13, 32'h0, 1'b0);
    access("lbu13", 1'b1, 1'b0, c_f3_bu, 32'h13, 32'h0, 1'b0);
    access("lh12",  1'b1, 1'b0, c_f3_h,  32'h12, 32'h0, 1'b0);
    access("lhu12", 1'b1, 1'b0, c_f3_hu, 32'h12, 32'h0, 1'b0);
    access("lb10",  1'b1, 1'b0, c_f3_b,  32'h10, 32'h0, 1'b0);
    access("sb11",  1'b0, 1'b1, c_f3_b,  32'h11, 32'hAAAAAA55, 1'b0);
    access("lw10b", 1'b1, 1'b0, c_f3_w,  32'h10, 32'h0, 1'b0);

    bad("lw12_mis",  1'b1, 1'b0, c_f3_w,  32'h12, 32'h0);
    bad("sh13_mis",  1'b0, 1'b1, c_f3_h,  32'h13, 32'hFFFF);
    bad("ld_f3_011", 1'b1, 1'b0, 3'b011,  32'h10, 32'h0);
    bad("st_f3_100", 1'b0, 1'b1, c_f3_bu, 32'h10, 32'hFF);
    access("lw10c", 1'b1, 1'b0, c_f3_w, 32'h10, 32'h0, 1'b0);

    // Reset in the middle of a store.
    access("sw20", 1'b0, 1'b1, c_f3_w, 32'h20, 32'hCAFEF00D, 1'b0);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b1; funct3 = c_f3_w; addr = 32'h20; wdata = 32'h1234;
`ifndef DMEM_LATENCY_EN
    model_store(c_f3_w, 32'h20, 32'h1234);
    exp_q.push_back(m_rdata);
`endif
    @(negedge clk);
    check("rstmid/stall_c0", {31'b0, stall}, {31'b0, LAT_EN});
    @(posedge clk); #1;
`ifndef DMEM_LATENCY_EN
    we = 1'b0;
`endif
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    check("rstmid/stall", {31'b0, stall}, 32'd0);
    check("rstmid/valid", {31'b0, valid}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1; re = 1'b0; we = 1'b0;
    m_rdata = 32'h0;
    @(negedge clk);
    check("rstmid/rdata", rdata, 32'd0);
    check("rstmid/stall_after", {31'b0, stall}, 32'd0);
    check("rstmid/valid_after", {31'b0, valid}, 32'd0);
    access("lw20", 1'b1, 1'b0, c_f3_w, 32'h20, 32'h0, 1'b0);

    // Back-to-back loads, then wrap-around and re&we treated as store.
    access("b2b_lw10", 1'b1, 1'b0, c_f3_w, 32'h10, 32'h0, 1'b0);
    access("b2b_lw20", 1'b1, 1'b0, c_f3_w, 32'h20, 32'h0, 1'b1);
    access("sw_wrap",  1'b1, 1'b1, c_f3_w, DEPTH*4 + 32'h4, 32'h0BADC0DE, 1'b1);
    access("lw4",      1'b1, 1'b0, c_f3_w, 32'h4, 32'h0, 1'b0);
    access("sh22",     1'b0, 1'b1, c_f3_h, 32'h22, 32'h9876BEEF, 1'b0);
    access("lw20b",    1'b1, 1'b0, c_f3_w, 32'h20, 32'h0, 1'b0);

    idle("idle_end");
    idle("idle_end2");
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: data memory size in 32-bit words; power of two.
REQ-002 SHALL have parameter MEM_DELAY, default 4: response latency in cycles; MEM_DELAY >= 1.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port re  input  1  load request; this is DRAM_RE from the control word.
REQ-006 SHALL have port we  input  1  store request; this is DRAM_WE from the control word.
REQ-007 SHALL have port funct3  input  3  access size and signedness, taken from instruction bits [14:12].
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port rdata  output  32  load result, extended to 32 bits.
REQ-011 SHALL have port valid  output  1  response strobe, high for one cycle.
REQ-012 SHALL have port stall  output  1  pipeline stall to the control unit.
REQ-013 SHALL have port err  output  1  misaligned access or illegal funct3, high for one cycle.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-015 In IDLE, an accepted request (re or we, legal, aligned) SHALL drive stall high combinationally in that same cycle (cycle 0).
- Next state: BUSY if MEM_DELAY > 1, else RESP.
REQ-016 In BUSY, a counter SHALL increment each cycle; the FSM SHALL go to RESP when the counter reaches MEM_DELAY-1. stall stays high throughout BUSY.
REQ-017 In RESP (cycle MEM_DELAY): stall=0, valid=1. Inputs in this cycle SHALL be ignored, because they belong to the same held instruction. Next state: IDLE.
REQ-018 The CU holds re, we, funct3, addr and wdata stable while stall=1. The block SHALL capture them at acceptance and use only the captured copy afterwards.
REQ-019 Memory read/write SHALL take effect at the edge entering RESP. rdata SHALL be registered at that edge and hold its value until the next load response.
REQ-020 Loads: funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
- The lane is selected by addr[1:0].
REQ-021 Stores: funct3 000 SB, 001 SH, 010 SW. Only the addressed byte lanes SHALL be written; other bytes SHALL be preserved.
REQ-022 If re and we are both high, the request SHALL be treated as a store.
REQ-023 Misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or an illegal funct3 SHALL cause:
- err=1 in the request cycle;
- no stall, no memory access, rdata unchanged;
- the FSM stays in IDLE.
REQ-024 The word index SHALL be addr[log2(DEPTH)+1:2]. Higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-025 With neither re nor we high in IDLE: stall=0, valid=0, err=0.

Reset
REQ-026 When nrst=0 at a rising edge: state=IDLE, counter=0, rdata=0, valid=0, err=0, stall=0 (combinationally while nrst=0).
REQ-027 Reset during BUSY SHALL abort the access with no memory write. Memory contents SHALL NOT be reset.

Configuration
REQ-028 With DMEM_LATENCY_EN defined, behaviour SHALL be as in REQ-014 to REQ-019.
REQ-029 Without DMEM_LATENCY_EN:
- stall SHALL be tied 0 and the FSM/counter removed;
- access SHALL occur at the request-cycle edge;
- valid and rdata SHALL appear the following cycle;
- MEM_DELAY SHALL be ignored.

Structure
REQ-030 The state enum and funct3 load/store codes SHALL live in shared package dmem_pkg.
REQ-031 Lane extraction, sign/zero extension and byte-enable generation SHALL be combinational sub-module dmem_align, instantiated once.

Verification
REQ-032 SW then LW. Stimulus: SW addr=0x10, wdata=0xDEADBEEF, MEM_DELAY=4; then LW addr=0x10. Required: stall high for cycles 0..3 of each access; valid at cycle 4; rdata=0xDEADBEEF.
REQ-033 Byte/half loads. Stimulus: LB addr=0x13 -> rdata=0xFFFFFFDE; LBU addr=0x13 -> 0x000000DE; LH addr=0x12 -> 0xFFFFDEAD.
REQ-034 Byte store preserves neighbours. Stimulus: SB addr=0x11, wdata=0x55; then LW addr=0x10. Required: rdata=0xDEAD55EF.
REQ-035 Misaligned load. Stimulus: LW addr=0x12. Required: err=1 for one cycle, stall=0, valid=0, rdata unchanged.
REQ-036 Reset mid-store. Stimulus: nrst=0 in cycle 2 of SW addr=0x20, wdata=0x1234. Required: FSM returns to IDLE, stall=0; a later LW addr=0x20 returns the prior contents.
REQ-037 Back-to-back and wrap. Stimulus: LW immediately after RESP is accepted at the next cycle; SW addr=DEPTH*4+0x4 then LW addr=0x4. Required: LW returns the written value.
